// File: rtl/instr_mem_loader.sv
// instr_mem_loader: instruction memory for the LEGv8 multicycle core with a
// byte-serial loader. UART bytes are assembled little-endian into words and
// written sequentially from word 0. The core fetches through a registered
// read port, and fetches are ignored while a load is in progress.
module instr_mem_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int INST_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start_in,
    input  logic [ADDR_WIDTH-1:0] load_count_in,
    input  logic [7:0]            rx_byte_in,
    input  logic                  rx_valid_in,
    input  logic                  fetch_req_in,
    input  logic [ADDR_WIDTH-1:0] fetch_addr_in,
    output logic [INST_WIDTH-1:0] instr_out,
    output logic                  instr_valid_out,
    output logic                  busy_out,
    output logic                  load_done_out
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int BYTES = INST_WIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [BCW-1:0]        LAST_BYTE  = BCW'(BYTES - 1);
    localparam logic [BCW-1:0]        CNT_ONE    = BCW'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   LEFT_ONE   = (ADDR_WIDTH + 1)'(1);
    // A requested count of zero stands for the full memory depth.
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    // Instruction storage; deliberately not cleared by reset.
    (* ramstyle = "M9K" *) logic [INST_WIDTH-1:0] r_mem [DEPTH];

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [BCW-1:0]        r_byte_cnt;
    logic [ADDR_WIDTH:0]   r_words_left;
    logic [INST_WIDTH-1:0] r_asm;
    logic [INST_WIDTH-1:0] r_instr;
    logic                  r_instr_valid;
    logic                  r_busy;
    logic                  r_load_done;

    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_wr_ptr_nxt;
    logic [BCW-1:0]        w_byte_cnt_nxt;
    logic [ADDR_WIDTH:0]   w_words_left_nxt;
    logic [INST_WIDTH-1:0] w_asm_nxt;
    logic [INST_WIDTH-1:0] w_word;
    logic                  w_we;
    logic                  w_done_nxt;
    logic                  w_fetch_ok;

    // Fetches are only honoured while idle (including the load_start cycle).
    assign w_fetch_ok = fetch_req_in && (r_state == ST_IDLE);

    // Loader next-state logic: byte assembly, word commit and load bookkeeping.
    always_comb begin
        w_state_nxt      = r_state;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_words_left_nxt = r_words_left;
        w_asm_nxt        = r_asm;
        w_we             = 1'b0;
        w_done_nxt       = 1'b0;
        // Current byte merged into the partial word at its little-endian slot.
        w_word           = r_asm;
        for (int b = 0; b < BYTES; b++) begin
            if (r_byte_cnt == BCW'(b)) begin
                w_word[8*b +: 8] = rx_byte_in;
            end else begin
                w_word[8*b +: 8] = r_asm[8*b +: 8];
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (load_start_in) begin
                    w_state_nxt      = ST_LOAD;
                    w_wr_ptr_nxt     = {ADDR_WIDTH{1'b0}};
                    w_byte_cnt_nxt   = {BCW{1'b0}};
                    w_words_left_nxt = (load_count_in == {ADDR_WIDTH{1'b0}}) ?
                                       FULL_COUNT : {1'b0, load_count_in};
                    w_asm_nxt        = {INST_WIDTH{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_start_in) begin
                    // Restart wins over a coincident byte, which is dropped.
                    w_wr_ptr_nxt     = {ADDR_WIDTH{1'b0}};
                    w_byte_cnt_nxt   = {BCW{1'b0}};
                    w_words_left_nxt = (load_count_in == {ADDR_WIDTH{1'b0}}) ?
                                       FULL_COUNT : {1'b0, load_count_in};
                    w_asm_nxt        = {INST_WIDTH{1'b0}};
                end else if (rx_valid_in) begin
                    if (r_byte_cnt == LAST_BYTE) begin
                        w_we             = 1'b1;
                        w_wr_ptr_nxt     = r_wr_ptr + PTR_ONE;
                        w_words_left_nxt = r_words_left - LEFT_ONE;
                        w_byte_cnt_nxt   = {BCW{1'b0}};
                        w_asm_nxt        = {INST_WIDTH{1'b0}};
                        if (r_words_left == LEFT_ONE) begin
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = ST_LOAD;
                        end
                    end else begin
                        w_byte_cnt_nxt = r_byte_cnt + CNT_ONE;
                        w_asm_nxt      = w_word;
                    end
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Loader state and bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= {ADDR_WIDTH{1'b0}};
            r_byte_cnt   <= {BCW{1'b0}};
            r_words_left <= {(ADDR_WIDTH + 1){1'b0}};
            r_asm        <= {INST_WIDTH{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_words_left <= w_words_left_nxt;
            r_asm        <= w_asm_nxt;
        end
    end

    // Memory write port: commits a word on the edge its last byte arrives.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // Registered outputs: synchronous fetch read, busy and done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr       <= {INST_WIDTH{1'b0}};
            r_instr_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_load_done   <= 1'b0;
        end else begin
            r_instr_valid <= w_fetch_ok;
            if (w_fetch_ok) begin
                r_instr <= r_mem[fetch_addr_in];
            end
            r_busy      <= (w_state_nxt == ST_LOAD);
            r_load_done <= w_done_nxt;
        end
    end

    assign instr_out       = r_instr;
    assign instr_valid_out = r_instr_valid;
    assign busy_out        = r_busy;
    assign load_done_out   = r_load_done;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: a model memory supplies expected
// fetch data, which is queued when a fetch is issued and popped on response.
module tb_instr_mem_loader;

    localparam int AW    = 6;
    localparam int IW    = 32;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start_in = 1'b0;
    logic [AW-1:0] load_count_in = '0;
    logic [7:0]    rx_byte_in = 8'h00;
    logic          rx_valid_in = 1'b0;
    logic          fetch_req_in = 1'b0;
    logic [AW-1:0] fetch_addr_in = '0;
    logic [IW-1:0] instr_out;
    logic          instr_valid_out;
    logic          busy_out;
    logic          load_done_out;

    int errors = 0;
    int checks = 0;
    logic [IW-1:0] model_mem [DEPTH];
    logic [IW-1:0] exp_q [$];
    logic [IW-1:0] exp;

    instr_mem_loader #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_start_in   (load_start_in),
        .load_count_in   (load_count_in),
        .rx_byte_in      (rx_byte_in),
        .rx_valid_in     (rx_valid_in),
        .fetch_req_in    (fetch_req_in),
        .fetch_addr_in   (fetch_addr_in),
        .instr_out       (instr_out),
        .instr_valid_out (instr_valid_out),
        .busy_out        (busy_out),
        .load_done_out   (load_done_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte_in  = b;
        rx_valid_in = 1'b1;
        tick();
        rx_valid_in = 1'b0;
    endtask

    task automatic start_load(input logic [AW-1:0] cnt);
        load_count_in = cnt;
        load_start_in = 1'b1;
        tick();
        load_start_in = 1'b0;
    endtask

    task automatic issue_fetch(input logic [AW-1:0] a);
        fetch_addr_in = a;
        fetch_req_in  = 1'b1;
        exp_q.push_back(model_mem[a]);
        tick();
        fetch_req_in  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({instr_out, instr_valid_out, busy_out, load_done_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got instr=%h valid=%b busy=%b done=%b, expected all 0",
                     instr_out, instr_valid_out, busy_out, load_done_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_load();
        logic [7:0] bb [8];
        bb = '{8'h20, 8'h00, 8'h80, 8'hD2, 8'h41, 8'h00, 8'h00, 8'h8B};
        start_load(6'd2);
        checks++;
        if (busy_out !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_start: got %b, expected 1", busy_out);
        end
        for (int i = 0; i < 8; i++) begin
            send_byte(bb[i]);
            checks++;
            if (load_done_out !== (i == 7) || busy_out !== (i != 7)) begin
                errors++;
                $display("FAIL basic_done_byte%0d: got done=%b busy=%b, expected done=%b busy=%b",
                         i, load_done_out, busy_out, i == 7, i != 7);
            end
        end
        model_mem[0] = 32'hD2800020;
        model_mem[1] = 32'h8B000041;
        for (int a = 0; a < 2; a++) begin
            issue_fetch(AW'(a));
            exp = exp_q.pop_front();
            checks++;
            if (instr_valid_out !== 1'b1 || instr_out !== exp) begin
                errors++;
                $display("FAIL basic_fetch%0d: got valid=%b data=%h, expected valid=1 data=%h",
                         a, instr_valid_out, instr_out, exp);
            end
        end
        tick();
        checks++;
        if (instr_valid_out !== 1'b0 || instr_out !== 32'h8B000041 || load_done_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: got valid=%b data=%h done=%b, expected valid=0 data=8b000041 done=0",
                     instr_valid_out, instr_out, load_done_out);
        end
    endtask

    task automatic test_full_depth();
        int early = 0;
        int noise_done = 0;
        start_load(6'd0);
        for (int w = 0; w < DEPTH; w++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte((b == 0) ? 8'(w) : 8'h00);
                if (!(w == DEPTH - 1 && b == 3) && (load_done_out !== 1'b0 || busy_out !== 1'b1))
                    early++;
            end
            model_mem[w] = IW'(w);
        end
        checks++;
        if (load_done_out !== 1'b1 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL full_done_256: got done=%b busy=%b, expected done=1 busy=0",
                     load_done_out, busy_out);
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL full_early_done: got %0d bad cycles, expected 0", early);
        end
        issue_fetch(6'd63);
        exp = exp_q.pop_front();
        checks++;
        if (instr_valid_out !== 1'b1 || instr_out !== exp || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL full_fetch63: got valid=%b data=%h busy=%b, expected valid=1 data=%h busy=0",
                     instr_valid_out, instr_out, busy_out, exp);
        end
        for (int b = 0; b < 4; b++) begin
            send_byte(8'hEE);
            if (load_done_out !== 1'b0 || busy_out !== 1'b0) noise_done++;
        end
        checks++;
        if (noise_done != 0) begin
            errors++;
            $display("FAIL full_extra_word: got %0d active cycles, expected 0", noise_done);
        end
        for (int a = 0; a < 2; a++) begin
            issue_fetch(AW'(a));
            exp = exp_q.pop_front();
            checks++;
            if (instr_valid_out !== 1'b1 || instr_out !== exp) begin
                errors++;
                $display("FAIL full_fetch%0d: got valid=%b data=%h, expected valid=1 data=%h",
                         a, instr_valid_out, instr_out, exp);
            end
        end
    endtask

    task automatic test_fetch_during_load();
        logic [7:0] bb [4];
        int bad = 0;
        bb = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
        // Fetch in the load_start cycle is still accepted.
        fetch_addr_in = 6'd1;
        fetch_req_in  = 1'b1;
        load_count_in = 6'd1;
        load_start_in = 1'b1;
        exp_q.push_back(model_mem[1]);
        tick();
        load_start_in = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (instr_valid_out !== 1'b1 || instr_out !== exp || busy_out !== 1'b1) begin
            errors++;
            $display("FAIL start_cycle_fetch: got valid=%b data=%h busy=%b, expected valid=1 data=%h busy=1",
                     instr_valid_out, instr_out, busy_out, exp);
        end
        for (int i = 0; i < 4; i++) begin
            send_byte(bb[i]);
            if (busy_out === 1'b1 && instr_valid_out !== 1'b0) bad++;
            if (i < 3) begin
                tick();
                if (busy_out !== 1'b1 || instr_valid_out !== 1'b0) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL busy_fetch_blocked: got %0d bad cycles, expected 0", bad);
        end
        checks++;
        if (busy_out !== 1'b0 || load_done_out !== 1'b1 || instr_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL busy_drop: got busy=%b done=%b valid=%b, expected busy=0 done=1 valid=0",
                     busy_out, load_done_out, instr_valid_out);
        end
        model_mem[0] = 32'hCAFEF00D;
        fetch_addr_in = 6'd0;
        exp_q.push_back(model_mem[0]);
        tick();
        fetch_req_in = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (instr_valid_out !== 1'b1 || instr_out !== exp) begin
            errors++;
            $display("FAIL done_cycle_fetch: got valid=%b data=%h, expected valid=1 data=%h",
                     instr_valid_out, instr_out, exp);
        end
        tick();
    endtask

    task automatic test_restart();
        logic [7:0] bb [4];
        int bad = 0;
        bb = '{8'h11, 8'h22, 8'h33, 8'h44};
        start_load(6'd1);
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        load_count_in = 6'd1;
        load_start_in = 1'b1;
        rx_byte_in    = 8'hFF;
        rx_valid_in   = 1'b1;
        tick();
        load_start_in = 1'b0;
        rx_valid_in   = 1'b0;
        if (busy_out !== 1'b1 || load_done_out !== 1'b0) bad++;
        for (int i = 0; i < 4; i++) begin
            send_byte(bb[i]);
            if (load_done_out !== (i == 3)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL restart_sequence: got %0d bad cycles, expected 0", bad);
        end
        model_mem[0] = 32'h44332211;
        for (int a = 0; a < 3; a++) begin
            issue_fetch(AW'(a));
            exp = exp_q.pop_front();
            checks++;
            if (instr_valid_out !== 1'b1 || instr_out !== exp) begin
                errors++;
                $display("FAIL restart_fetch%0d: got valid=%b data=%h, expected valid=1 data=%h",
                         a, instr_valid_out, instr_out, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] bb [4];
        bb = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        issue_fetch(6'd3);
        exp = exp_q.pop_front();
        checks++;
        if (instr_valid_out !== 1'b1 || instr_out !== exp) begin
            errors++;
            $display("FAIL areset_prefetch: got valid=%b data=%h, expected valid=1 data=%h",
                     instr_valid_out, instr_out, exp);
        end
        start_load(6'd2);
        for (int i = 0; i < 4; i++) send_byte(bb[i]);
        model_mem[0] = 32'hAABBCCDD;
        send_byte(8'h55);
        send_byte(8'h66);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({instr_out, instr_valid_out, busy_out, load_done_out} !== '0) begin
            errors++;
            $display("FAIL areset_outputs: got instr=%h valid=%b busy=%b done=%b, expected all 0",
                     instr_out, instr_valid_out, busy_out, load_done_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 2; a++) begin
            issue_fetch(AW'(a));
            exp = exp_q.pop_front();
            checks++;
            if (instr_valid_out !== 1'b1 || instr_out !== exp || busy_out !== 1'b0) begin
                errors++;
                $display("FAIL areset_fetch%0d: got valid=%b data=%h busy=%b, expected valid=1 data=%h busy=0",
                         a, instr_valid_out, instr_out, busy_out, exp);
            end
        end
        // A fresh load after reset must start from a clean byte counter.
        start_load(6'd1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        checks++;
        if (load_done_out !== 1'b1) begin
            errors++;
            $display("FAIL areset_reload_done: got %b, expected 1", load_done_out);
        end
        model_mem[0] = 32'h04030201;
        issue_fetch(6'd0);
        exp = exp_q.pop_front();
        checks++;
        if (instr_valid_out !== 1'b1 || instr_out !== exp) begin
            errors++;
            $display("FAIL areset_reload_fetch: got valid=%b data=%h, expected valid=1 data=%h",
                     instr_valid_out, instr_out, exp);
        end
    endtask

    task automatic test_idle_noise();
        int bad = 0;
        for (int i = 0; i < 8; i++) begin
            send_byte(8'($urandom_range(0, 255)));
            if (load_done_out !== 1'b0 || busy_out !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_noise_flags: got %0d active cycles, expected 0", bad);
        end
        for (int a = 0; a < 4; a++) begin
            issue_fetch(AW'(a));
            exp = exp_q.pop_front();
            checks++;
            if (instr_valid_out !== 1'b1 || instr_out !== exp) begin
                errors++;
                $display("FAIL idle_noise_fetch%0d: got valid=%b data=%h, expected valid=1 data=%h",
                         a, instr_valid_out, instr_out, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_full_depth();
        test_fetch_during_load();
        test_restart();
        test_async_reset();
        test_idle_noise();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

endmodule
